// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection and EX operand bypass.
// Optional feature macro: IDEX_FORWARD_EN
//   defined   -> operands forwarded from EX/MEM and MEM/WB, stall only on load-use
//   undefined -> operands taken straight from the register file, stall on any RAW match
module id_ex_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_aluop,
    input  logic        id_alusrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [1:0]  id_wdsel,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_regwrite,
    input  logic [31:0] exmem_aluout,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_regwrite,
    input  logic [31:0] memwb_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [4:0]  ex_aluop,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [1:0]  ex_wdsel
);

    localparam logic [4:0] ALUOP_NOP = 5'd0;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [4:0]  r_aluop;
    logic        r_alusrc;
    logic        r_regwrite;
    logic        r_memread;
    logic        r_memwrite;
    logic [1:0]  r_wdsel;

    logic        hazard;
    logic        bubble;
    logic [31:0] fa;
    logic [31:0] fb;

`ifdef IDEX_FORWARD_EN
    // Youngest producer wins; x0 is never a bypass target.
    function automatic logic [31:0] fwd_operand(input logic [4:0] rs, input logic [31:0] reg_data);
        logic [31:0] val;
        val = reg_data;
        if (rs != 5'd0) begin
            if (exmem_regwrite && (exmem_rd == rs))
                val = exmem_aluout;
            else if (memwb_regwrite && (memwb_rd == rs))
                val = memwb_wdata;
        end
        return val;
    endfunction
`else
    // A nonzero source register still has a write in flight somewhere downstream.
    function automatic logic raw_match(input logic [4:0] rs);
        return (rs != 5'd0) &&
               ((r_valid && r_regwrite && (r_rd == rs)) ||
                (exmem_regwrite && (exmem_rd == rs)) ||
                (memwb_regwrite && (memwb_rd == rs)));
    endfunction

    logic unused_bypass;
    assign unused_bypass = ^{exmem_aluout, memwb_wdata};
`endif

    // Hazard detection: decide whether the ID instruction must wait, and whether EX gets a bubble.
    always_comb begin
        hazard = 1'b0;
`ifdef IDEX_FORWARD_EN
        hazard = id_valid & r_valid & r_memread & (r_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == r_rd)) | (id_use_rs2 & (id_rs2 == r_rd)));
`else
        hazard = id_valid & ((id_use_rs1 & raw_match(id_rs1)) | (id_use_rs2 & raw_match(id_rs2)));
`endif
        stall  = hazard & ~flush & rstn;
        bubble = stall | flush | ~id_valid;
    end

    // ID/EX register: data fields always follow ID, control fields collapse to a bubble when killed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_aluop    <= ALUOP_NOP;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_wdsel    <= 2'd0;
        end else begin
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_alusrc   <= id_alusrc;
            if (bubble) begin
                r_valid    <= 1'b0;
                r_rd       <= 5'd0;
                r_aluop    <= ALUOP_NOP;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_wdsel    <= 2'd0;
            end else begin
                r_valid    <= 1'b1;
                r_rd       <= id_rd;
                r_aluop    <= id_aluop;
                r_regwrite <= id_regwrite;
                r_memread  <= id_memread;
                r_memwrite <= id_memwrite;
                r_wdsel    <= id_wdsel;
            end
        end
    end

    // Operand selection for the EX stage from registered state and the bypass buses.
    always_comb begin
`ifdef IDEX_FORWARD_EN
        fa = fwd_operand(r_rs1, r_rs1_data);
        fb = fwd_operand(r_rs2, r_rs2_data);
`else
        fa = r_rs1_data;
        fb = r_rs2_data;
`endif
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_A          = fa;
    assign ex_B          = r_alusrc ? r_imm : fb;
    assign ex_store_data = fb;
    assign ex_aluop      = r_aluop;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_regwrite & r_valid;
    assign ex_memread    = r_memread & r_valid;
    assign ex_memwrite   = r_memwrite & r_valid;
    assign ex_wdsel      = r_wdsel;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  sole clock, all state on rising edge; rstn  in  1  asynchronous active-low reset.
REQ-002 SHALL have ID-side inputs: id_valid 1; id_pc 32; id_rs1_data 32; id_rs2_data 32; id_imm 32; id_rs1 5; id_rs2 5; id_rd 5; id_use_rs1 1; id_use_rs2 1; id_aluop 5; id_alusrc 1; id_regwrite 1; id_memread 1; id_memwrite 1; id_wdsel 2.
REQ-003 SHALL have bypass inputs: exmem_rd 5; exmem_regwrite 1; exmem_aluout 32; memwb_rd 5; memwb_regwrite 1; memwb_wdata 32; flush 1 (taken branch/jump resolved in EX).
REQ-004 SHALL have outputs: stall 1 (hold PC and IF/ID); ex_valid 1; ex_pc 32; ex_A 32; ex_B 32; ex_aluop 5; ex_store_data 32; ex_rd 5; ex_regwrite 1; ex_memread 1; ex_memwrite 1; ex_wdsel 2.

Function
REQ-005 SHALL register all ID-side fields into an ID/EX register on each rising clk edge, giving one cycle of latency from ID to EX.
REQ-006 SHALL load a bubble when stall=1 or flush=1: ex_valid, ex_regwrite, ex_memread, ex_memwrite and ex_rd become 0; ex_aluop becomes ALUOp_nop; data fields are don't-care.
REQ-007 SHALL give flush priority over stall: with flush=1, stall=0 and a bubble is loaded.
REQ-008 SHALL gate every EX-side control output with ex_valid; an invalid entry never writes registers or memory.
REQ-009 SHALL assert stall combinationally on load-use: id_valid & ex_valid & ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-010 SHALL, while stalling, hold the ID instruction upstream; the stall drops the cycle after the load leaves EX.
REQ-011 SHALL compute forwarded operand fa from the registered rs1 as: exmem_aluout if exmem_regwrite & exmem_rd!=0 & exmem_rd==rs1; else memwb_wdata if memwb_regwrite & memwb_rd!=0 & memwb_rd==rs1; else registered rs1_data.
REQ-012 SHALL compute fb identically for rs2; EX/MEM takes priority over MEM/WB when both match.
REQ-013 SHALL never forward for register x0; reading x0 yields the registered value (0).
REQ-014 SHALL drive ex_A=fa, ex_B=(alusrc ? imm : fb), ex_store_data=fb, all combinational from registered state and bypass inputs.
REQ-015 SHALL pass ex_pc unmodified so the ALU can form auipc results.
REQ-016 SHALL, when id_valid=0 and no stall or flush is active, load an entry with ex_valid=0.

Reset
REQ-017 SHALL, on rstn low and regardless of clk, clear every ID/EX register: ex_valid=0, ex_pc=0, ex_rd=0, ex_aluop=ALUOp_nop, all control bits 0, all data 0.
REQ-018 SHALL, during and after reset, produce ex_A=0, ex_B=0, ex_store_data=0 and stall=0.
REQ-019 SHALL, if reset asserts mid-stall, drop the stall immediately; no pending entry survives.

Configuration
REQ-020 SHALL, with macro IDEX_FORWARD_EN defined, implement the forwarding of REQ-011..REQ-013 and stall only on load-use.
REQ-021 SHALL, without IDEX_FORWARD_EN, use registered rs1_data and rs2_data directly, and widen stall to any RAW match of a used id_rs1/id_rs2 (nonzero) against a valid ex_rd with ex_regwrite, exmem_rd with exmem_regwrite, or memwb_rd with memwb_regwrite.

Verification
REQ-022 SHALL test: addi x1=5 with EX/MEM rd=1, aluout=5, and next add x2,x1,x1 (reg x1=0) -> ex_A=5, ex_B=5.
REQ-023 SHALL test: EX/MEM rd=3 data 0x11 and MEM/WB rd=3 data 0x22, consumer reads x3 -> ex_A=0x11.
REQ-024 SHALL test: lw x4 in EX and ID add x5,x4,x0 -> stall=1 for exactly one cycle, bubble with ex_valid=0, then add issues with x4 taken from MEM/WB.
REQ-025 SHALL test: flush=1 together with a load-use condition -> stall=0 and a bubble is loaded; the next entry is the fetch-target instruction.
REQ-026 SHALL test: MEM/WB rd=0, regwrite=1, wdata=0xDEAD and consumer reads x0 -> ex_A=0.
REQ-027 SHALL test: rstn pulled low mid-stream -> all outputs 0 asynchronously, and ex_aluop=ALUOp_nop.
